// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM init sequencer: state encoding, pending-command
// encoding and default timing constants also used by the refresh counter.
package sdram_pkg;

    localparam int unsigned SDRAM_POWERUP_CYCLES = 32'd20000;
    localparam int unsigned SDRAM_REFRESH_TIMES  = 32'd8;
    localparam int unsigned SDRAM_GAP_CYCLES     = 32'd4;

    localparam logic [2:0] ST_WAIT_POWERUP = 3'd0;
    localparam logic [2:0] ST_PRECHARGE    = 3'd1;
    localparam logic [2:0] ST_REFRESH      = 3'd2;
    localparam logic [2:0] ST_CONFIG       = 3'd3;
    localparam logic [2:0] ST_GAP          = 3'd4;
    localparam logic [2:0] ST_DONE         = 3'd5;

    typedef enum logic [1:0] {
        NEXT_REFRESH = 2'd0,
        NEXT_CONFIG  = 2'd1,
        NEXT_DONE    = 2'd2
    } next_cmd_e;

    // State the sequencer enters when the gap after a command expires
    function automatic logic [2:0] cmd_state(input next_cmd_e cmd);
        logic [2:0] st;
        case (cmd)
            NEXT_REFRESH: st = ST_REFRESH;
            NEXT_CONFIG:  st = ST_CONFIG;
            NEXT_DONE:    st = ST_DONE;
            default:      st = ST_WAIT_POWERUP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sdram_init_controller_if.sv
// Init request/ack handshake between the init sequencer (master) and the
// SDRAM system controller (slave).
interface sdram_init_controller_if;

    logic sdram_inside_order_ack;
    logic sdram_init_precharge_req;
    logic sdram_init_refresh_req;
    logic sdram_init_config_req;
    logic sdram_init_done;
    logic sdram_init_busy;

    modport master (
        input  sdram_inside_order_ack,
        output sdram_init_precharge_req,
        output sdram_init_refresh_req,
        output sdram_init_config_req,
        output sdram_init_done,
        output sdram_init_busy
    );

    modport slave (
        output sdram_inside_order_ack,
        input  sdram_init_precharge_req,
        input  sdram_init_refresh_req,
        input  sdram_init_config_req,
        input  sdram_init_done,
        input  sdram_init_busy
    );

endinterface

// File: rtl/sdram_init_timer.sv
// Clearable up-counter with a terminal-count compare; shared by the power-up
// wait and the post-command gap wait.
module sdram_init_timer #(
    parameter int unsigned WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise count up and hold at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {WIDTH{1'b0}};
        end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/sdram_init_controller.sv
// Power-up init sequencer: wait, precharge-all, N auto-refreshes, mode-register
// set, then a sticky done flag. Requests are level, held until acked.
module sdram_init_controller
    import sdram_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = SDRAM_POWERUP_CYCLES,
    parameter int unsigned REFRESH_TIMES  = SDRAM_REFRESH_TIMES,
    parameter int unsigned GAP_CYCLES     = SDRAM_GAP_CYCLES,
    parameter int unsigned CNT_WIDTH      = 15,
    parameter int unsigned REF_CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sdram_init_controller_if.master   bus
);

    localparam logic [CNT_WIDTH-1:0]     PU_TERM  = CNT_WIDTH'(POWERUP_CYCLES - 32'd1);
    localparam logic [CNT_WIDTH-1:0]     GAP_TERM = CNT_WIDTH'(GAP_CYCLES - 32'd1);
    localparam logic [REF_CNT_WIDTH-1:0] REF_MAX  = REF_CNT_WIDTH'(REFRESH_TIMES);

    logic [2:0]               state_q,   state_d;
    next_cmd_e                next_q,    next_d;
    logic [REF_CNT_WIDTH-1:0] ref_cnt_q, ref_cnt_d;
    logic                     pre_q,     pre_d;
    logic                     refr_q,    refr_d;
    logic                     cfg_q,     cfg_d;
    logic                     done_q,    done_d;
    logic                     busy_q,    busy_d;

    logic                     timer_en_s;
    logic                     timer_clr_s;
    logic                     timer_tc_s;
    logic [CNT_WIDTH-1:0]     timer_term_s;
    logic [REF_CNT_WIDTH-1:0] ref_cnt_inc_s;
    logic                     ack_s;

    assign ack_s         = bus.sdram_inside_order_ack;
    assign ref_cnt_inc_s = ref_cnt_q + {{(REF_CNT_WIDTH-1){1'b0}}, 1'b1};

    // Terminal count depends on which wait the timer is serving
    always_comb begin
        if (state_q == ST_WAIT_POWERUP) begin
            timer_term_s = PU_TERM;
        end else begin
            timer_term_s = GAP_TERM;
        end
    end

    sdram_init_timer #(
        .WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (timer_en_s),
        .clr_i  (timer_clr_s),
        .term_i (timer_term_s),
        .tc_o   (timer_tc_s)
    );

    // Sequencer next-state; request outputs are computed one cycle ahead so they
    // drop on the ack edge and rise on the edge that leaves a wait state.
    always_comb begin
        state_d     = state_q;
        next_d      = next_q;
        ref_cnt_d   = ref_cnt_q;
        pre_d       = 1'b0;
        refr_d      = 1'b0;
        cfg_d       = 1'b0;
        done_d      = done_q;
        busy_d      = busy_q;
        timer_en_s  = 1'b0;
        timer_clr_s = 1'b0;
        case (state_q)
            ST_WAIT_POWERUP: begin
                timer_en_s = 1'b1;
                if (timer_tc_s) begin
                    timer_clr_s = 1'b1;
                    state_d     = ST_PRECHARGE;
                    pre_d       = 1'b1;
                end else begin
                    pre_d       = 1'b0;
                end
            end
            ST_PRECHARGE: begin
                if (ack_s) begin
                    state_d = ST_GAP;
                    next_d  = NEXT_REFRESH;
                end else begin
                    pre_d   = 1'b1;
                end
            end
            ST_REFRESH: begin
                if (ack_s) begin
                    ref_cnt_d = ref_cnt_inc_s;
                    state_d   = ST_GAP;
                    if (ref_cnt_inc_s < REF_MAX) begin
                        next_d = NEXT_REFRESH;
                    end else begin
                        next_d = NEXT_CONFIG;
                    end
                end else begin
                    refr_d    = 1'b1;
                end
            end
            ST_CONFIG: begin
                if (ack_s) begin
                    state_d = ST_GAP;
                    next_d  = NEXT_DONE;
                end else begin
                    cfg_d   = 1'b1;
                end
            end
            ST_GAP: begin
                timer_en_s = 1'b1;
                if (timer_tc_s) begin
                    timer_clr_s = 1'b1;
                    state_d     = cmd_state(next_q);
                    case (next_q)
                        NEXT_REFRESH: refr_d = 1'b1;
                        NEXT_CONFIG:  cfg_d  = 1'b1;
                        NEXT_DONE: begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end
                        default: begin
                            done_d = 1'b0;
                            busy_d = 1'b1;
                        end
                    endcase
                end else begin
                    timer_clr_s = 1'b0;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                state_d = ST_WAIT_POWERUP;
                done_d  = 1'b0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Sequencer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT_POWERUP;
            next_q    <= NEXT_REFRESH;
            ref_cnt_q <= {REF_CNT_WIDTH{1'b0}};
            pre_q     <= 1'b0;
            refr_q    <= 1'b0;
            cfg_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            next_q    <= next_d;
            ref_cnt_q <= ref_cnt_d;
            pre_q     <= pre_d;
            refr_q    <= refr_d;
            cfg_q     <= cfg_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sdram_init_precharge_req = pre_q;
    assign bus.sdram_init_refresh_req   = refr_q;
    assign bus.sdram_init_config_req    = cfg_q;
    assign bus.sdram_init_done          = done_q;
    assign bus.sdram_init_busy          = busy_q;

endmodule
